// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply-divide unit: iterative radix-2 shift-add multiply and
// restoring divide with one-cycle sign fix-up, plus direct MTHI/MTLO writes.
// Fixed latency of N+1 edges from issue to HI/LO update.
module hilo_muldiv_unit #(
    parameter int unsigned N = 32
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [2:0]   Op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Flush,
    output logic         Busy,
    output logic         Done,
    output logic [N-1:0] Hi,
    output logic [N-1:0] Lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    localparam logic [N-1:0] C_LAST = N'(N - 1);

    state_t         r_state;
    logic           r_busy;
    logic           r_done;
    logic [N-1:0]   r_hi;
    logic [N-1:0]   r_lo;
    logic [N-1:0]   r_cnt;
    logic [2*N-1:0] r_acc;
    logic [2*N-1:0] r_mcand;
    logic [N-1:0]   r_opa;      // dividend shifting out, quotient shifting in
    logic [N-1:0]   r_opb;      // multiplier (shifts right) or divisor
    logic [N-1:0]   r_rem;
    logic           r_is_div;
    logic           r_neg_res;  // operand signs differ: negate product/quotient
    logic           r_neg_rem;  // dividend sign: remainder follows it
    logic           r_bzero;

    logic           w_sgn_a;
    logic           w_sgn_b;
    logic [N-1:0]   w_abs_a;
    logic [N-1:0]   w_abs_b;
    logic [N:0]     w_shift;
    logic [N:0]     w_diff;
    logic [2*N-1:0] w_prod;
    logic [N-1:0]   w_quo;
    logic [N-1:0]   w_rem;

    // Operand sign capture and magnitude conversion for signed ops
    always_comb begin
        w_sgn_a = ~Op[0] & A[N-1];
        w_sgn_b = ~Op[0] & B[N-1];
        w_abs_a = w_sgn_a ? -A : A;
        w_abs_b = w_sgn_b ? -B : B;
    end

    // Restoring divide trial subtraction and final sign correction
    always_comb begin
        w_shift = {r_rem, r_opa[N-1]};
        w_diff  = w_shift - {1'b0, r_opb};
        w_prod  = r_neg_res ? -r_acc : r_acc;
        // divide-by-zero forces an all-ones quotient whatever the signs;
        // the remainder path already yields A because the magnitude passes through
        w_quo   = r_bzero ? '1 : (r_neg_res ? -r_opa : r_opa);
        w_rem   = r_neg_rem ? -r_rem : r_rem;
    end

    // Control FSM, datapath iteration and architectural HI/LO registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_rem     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_bzero   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start && !Flush) begin
                        case (Op)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                r_cnt     <= '0;
                                r_acc     <= '0;
                                r_rem     <= '0;
                                r_mcand   <= {{N{1'b0}}, w_abs_a};
                                r_opa     <= w_abs_a;
                                r_opb     <= w_abs_b;
                                r_is_div  <= Op[1];
                                r_neg_res <= w_sgn_a ^ w_sgn_b;
                                r_neg_rem <= w_sgn_a;
                                r_bzero   <= (B == '0);
                                r_busy    <= 1'b1;
                                r_state   <= Op[1] ? S_DIV : S_MUL;
                            end
                            3'b100: begin
                                r_hi   <= A;
                                r_done <= 1'b1;
                            end
                            3'b101: begin
                                r_lo   <= A;
                                r_done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (Flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (r_opb[0])
                            r_acc <= r_acc + r_mcand;
                        r_mcand <= r_mcand << 1;
                        r_opb   <= r_opb >> 1;
                        r_cnt   <= r_cnt + 1'b1;
                        if (r_cnt == C_LAST)
                            r_state <= S_FIX;
                    end
                end
                S_DIV: begin
                    if (Flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (!w_diff[N]) begin
                            r_rem <= w_diff[N-1:0];
                            r_opa <= {r_opa[N-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[N-1:0];
                            r_opa <= {r_opa[N-2:0], 1'b0};
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == C_LAST)
                            r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (!Flush) begin
                        r_done <= 1'b1;
                        if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod[2*N-1:N];
                            r_lo <= w_prod[N-1:0];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = r_busy;
    assign Done = r_done;
    assign Hi   = r_hi;
    assign Lo   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed corner cases plus
// randomized operations against an arithmetic reference model.
module tb_hilo_muldiv_unit;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int n_checks;
    int n_errors;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    hilo_muldiv_unit #(.N(32)) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .Op    (Op),
        .A     (A),
        .B     (B),
        .Flush (Flush),
        .Busy  (Busy),
        .Done  (Done),
        .Hi    (Hi),
        .Lo    (Lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural results
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         inout logic [31:0] hi, inout logic [31:0] lo);
        longint      sp;
        longint      sq;
        longint      sr;
        logic [63:0] up;
        case (op)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                up = sp;
                hi = up[63:32];
                lo = up[31:0];
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                hi = up[63:32];
                lo = up[31:0];
            end
            3'd2: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    lo = sq[31:0];
                    hi = sr[31:0];
                end
            end
            3'd3: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            3'd4: hi = a;
            3'd5: lo = a;
            default: ;
        endcase
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Issue one op and check latency, Done pulse and results against the model
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int busy_cnt;
        model(op, a, b, m_hi, m_lo);
        issue(op, a, b);
        if (op >= 3'd4) begin
            check("mt_busy", Busy, 0);
        end else begin
            busy_cnt = 0;
            while (Busy && busy_cnt < 100) begin
                if (Done) check("done_early", Done, 0);
                busy_cnt++;
                @(negedge Clk);
            end
            check("busy_cycles", busy_cnt, 33);
        end
        check("done_pulse", Done, 1);
        check("hi", Hi, m_hi);
        check("lo", Lo, m_lo);
        @(negedge Clk);
        check("done_drop", Done, 0);
    endtask

    initial begin
        int busy_cnt;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks = 0;
        n_errors = 0;
        m_hi  = '0;
        m_lo  = '0;
        Reset = 1'b0;
        Start = 1'b0;
        Flush = 1'b0;
        Op    = '0;
        A     = '0;
        B     = '0;
        #1;
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_hi", Hi, 0);
        check("rst_lo", Lo, 0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;

        // Directed corner cases
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2);
        check("multu_hi_const", Hi, 32'h0000_0001);
        check("multu_lo_const", Lo, 32'hFFFF_FFFE);
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7);
        check("mult_lo_const", Lo, 32'hFFFF_FFEB);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        check("div_lo_const", Lo, 32'hFFFF_FFFD);
        check("div_hi_const", Hi, 32'hFFFF_FFFF);
        run_op(3'd3, 32'd100, 32'd0);
        check("divu0_lo_const", Lo, 32'hFFFF_FFFF);
        check("divu0_hi_const", Hi, 32'd100);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("ovf_lo_const", Lo, 32'h8000_0000);
        check("ovf_hi_const", Hi, 32'd0);
        run_op(3'd5, 32'h1234_5678, 32'd0);
        check("mtlo_const", Lo, 32'h1234_5678);
        run_op(3'd4, 32'hCAFE_F00D, 32'd0);

        // Reserved opcode: nothing happens
        issue(3'd6, 32'hDEAD_BEEF, 32'd3);
        check("rsv_busy", Busy, 0);
        check("rsv_done", Done, 0);
        check("rsv_hi", Hi, m_hi);
        check("rsv_lo", Lo, m_lo);

        // Start together with Flush in IDLE is ignored
        @(negedge Clk);
        Flush = 1'b1;
        issue(3'd5, 32'h5555_AAAA, 32'd0);
        Flush = 1'b0;
        check("sflush_busy", Busy, 0);
        check("sflush_done", Done, 0);
        check("sflush_lo", Lo, m_lo);

        // DIVU flushed at cycle 10, with a second Start ignored while busy
        issue(3'd3, 32'd1000, 32'd7);
        busy_cnt = 1;
        while (busy_cnt < 10) begin
            if (busy_cnt == 3) begin
                Start = 1'b1;
                Op    = 3'd5;
                A     = 32'h0BAD_0BAD;
            end else begin
                Start = 1'b0;
            end
            busy_cnt++;
            @(negedge Clk);
        end
        Start = 1'b0;
        check("pre_flush_busy", Busy, 1);
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        check("flush_busy", Busy, 0);
        check("flush_done", Done, 0);
        check("flush_hi", Hi, m_hi);
        check("flush_lo", Lo, m_lo);
        @(negedge Clk);
        check("flush_done2", Done, 0);

        // Asynchronous reset mid-multiply
        issue(3'd0, 32'h7654_3210, 32'h0000_1234);
        @(negedge Clk);
        @(negedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        check("arst_busy", Busy, 0);
        check("arst_done", Done, 0);
        check("arst_hi", Hi, 0);
        check("arst_lo", Lo, 0);
        m_hi = '0;
        m_lo = '0;
        @(negedge Clk);
        Reset = 1'b1;
        run_op(3'd1, 32'd12345, 32'd678);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 5));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 20));
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 300));
            run_op(rop, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
